ysyx_24100006_axi_arbiter: RTL and testbench

Two-master, one-slave AXI4 arbiter sharing the single memory slave between the instruction-fetch master (m0, IFU) and the load/store master (m1, LSU). Grants whole transactions (read burst or single write) to one master at a time and forwards its channels to the slave. Non-owners see all ready/valid signals held low.

---
 rtl/ysyx_24100006_axi_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_ysyx_24100006_axi_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_axi_arbiter.sv
// Two-master / one-slave AXI4 arbiter: IFU (m0) and LSU (m1) share one memory slave,
// one whole transaction at a time. Optional macro: ARB_ROUND_ROBIN_EN (else m1 has fixed priority).
module ysyx_24100006_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  // master 0 (IFU)
  input  logic [ADDR_W-1:0]     m0_araddr,
  input  logic [7:0]            m0_arlen,
  input  logic [2:0]            m0_arsize,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [ADDR_W-1:0]     m0_awaddr,
  input  logic [7:0]            m0_awlen,
  input  logic [2:0]            m0_awsize,
  input  logic                  m0_awvalid,
  output logic                  m0_awready,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  input  logic                  m0_wlast,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  output logic [1:0]            m0_bresp,
  output logic                  m0_bvalid,
  input  logic                  m0_bready,

  // master 1 (LSU)
  input  logic [ADDR_W-1:0]     m1_araddr,
  input  logic [7:0]            m1_arlen,
  input  logic [2:0]            m1_arsize,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic [7:0]            m1_awlen,
  input  logic [2:0]            m1_awsize,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wlast,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [1:0]            m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,

  // slave
  output logic [ADDR_W-1:0]     s_araddr,
  output logic [7:0]            s_arlen,
  output logic [2:0]            s_arsize,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic [7:0]            s_awlen,
  output logic [2:0]            s_awsize,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wlast,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;

  logic req0, req1;
  logic winner, winner_rd;
  logic rd_act, wr_act;
  logic rd0, rd1, wr0, wr1;
  logic rd_done, wr_done;

  assign req0 = m0_arvalid | m0_awvalid;
  assign req1 = m1_arvalid | m1_awvalid;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    winner = (req0 && req1) ? ~last_grant_q : req1;
`else
    winner = req1;
`endif
  end

  // Inside one master a pending read is served before its write.
  assign winner_rd = winner ? m1_arvalid : m0_arvalid;

  assign rd_done = s_rvalid & s_rready & s_rlast;
  assign wr_done = s_bvalid & s_bready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d      = winner;
          last_grant_d = winner;
          state_d      = winner_rd ? ST_READ : ST_WRITE;
        end
      end
      ST_READ:  if (rd_done) state_d = ST_IDLE;
      ST_WRITE: if (wr_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rd_act = (state_q == ST_READ);
  assign wr_act = (state_q == ST_WRITE);
  assign rd0    = rd_act & ~owner_q;
  assign rd1    = rd_act &  owner_q;
  assign wr0    = wr_act & ~owner_q;
  assign wr1    = wr_act &  owner_q;

  // Payloads follow the owner unconditionally; only the handshakes are gated.
  assign s_araddr  = owner_q ? m1_araddr  : m0_araddr;
  assign s_arlen   = owner_q ? m1_arlen   : m0_arlen;
  assign s_arsize  = owner_q ? m1_arsize  : m0_arsize;
  assign s_arvalid = rd_act & (owner_q ? m1_arvalid : m0_arvalid);
  assign s_rready  = rd_act & (owner_q ? m1_rready  : m0_rready);

  assign s_awaddr  = owner_q ? m1_awaddr  : m0_awaddr;
  assign s_awlen   = owner_q ? m1_awlen   : m0_awlen;
  assign s_awsize  = owner_q ? m1_awsize  : m0_awsize;
  assign s_awvalid = wr_act & (owner_q ? m1_awvalid : m0_awvalid);
  assign s_wdata   = owner_q ? m1_wdata   : m0_wdata;
  assign s_wstrb   = owner_q ? m1_wstrb   : m0_wstrb;
  assign s_wlast   = owner_q ? m1_wlast   : m0_wlast;
  assign s_wvalid  = wr_act & (owner_q ? m1_wvalid : m0_wvalid);
  assign s_bready  = wr_act & (owner_q ? m1_bready : m0_bready);

  assign m0_arready = rd0 & s_arready;
  assign m0_rvalid  = rd0 & s_rvalid;
  assign m0_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;
  assign m0_rlast   = s_rlast;
  assign m0_awready = wr0 & s_awready;
  assign m0_wready  = wr0 & s_wready;
  assign m0_bvalid  = wr0 & s_bvalid;
  assign m0_bresp   = s_bresp;

  assign m1_arready = rd1 & s_arready;
  assign m1_rvalid  = rd1 & s_rvalid;
  assign m1_rdata   = s_rdata;
  assign m1_rresp   = s_rresp;
  assign m1_rlast   = s_rlast;
  assign m1_awready = wr1 & s_awready;
  assign m1_wready  = wr1 & s_wready;
  assign m1_bvalid  = wr1 & s_bvalid;
  assign m1_bresp   = s_bresp;

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Directed self-checking bench for ysyx_24100006_axi_arbiter; the bench plays both masters
// and a simple always-ready slave. Expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_ysyx_24100006_axi_arbiter;

  logic clk;
  logic reset;

  logic [31:0] m_araddr [2];
  logic [7:0]  m_arlen  [2];
  logic [2:0]  m_arsize [2];
  logic [1:0]  m_arvalid;
  logic [1:0]  m_rready;
  logic [31:0] m_awaddr [2];
  logic [7:0]  m_awlen  [2];
  logic [2:0]  m_awsize [2];
  logic [1:0]  m_awvalid;
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wstrb  [2];
  logic [1:0]  m_wlast;
  logic [1:0]  m_wvalid;
  logic [1:0]  m_bready;

  wire  [1:0]  m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid;
  wire  [31:0] m_rdata [2];
  wire  [1:0]  m_rresp [2];
  wire  [1:0]  m_bresp [2];

  wire  [31:0] s_araddr, s_awaddr, s_wdata;
  wire  [7:0]  s_arlen, s_awlen;
  wire  [2:0]  s_arsize, s_awsize;
  wire  [3:0]  s_wstrb;
  wire         s_arvalid, s_rready, s_awvalid, s_wlast, s_wvalid, s_bready;
  logic        s_arready, s_rlast, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_24100006_axi_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_araddr(m_araddr[0]), .m0_arlen(m_arlen[0]), .m0_arsize(m_arsize[0]),
    .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
    .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rlast(m_rlast[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
    .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awsize(m_awsize[0]),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
    .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m1_araddr(m_araddr[1]), .m1_arlen(m_arlen[1]), .m1_arsize(m_arsize[1]),
    .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
    .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rlast(m_rlast[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
    .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awsize(m_awsize[1]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
    .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual running, required done)");
    $fatal(1);
  end

  // Every valid/ready output of the arbiter; all zero in IDLE and during reset.
  wire [14:0] all_vr = {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
                        m_arready, m_rvalid, m_awready, m_wready, m_bvalid};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_read(input bit m, input logic [31:0] addr, input logic [7:0] len);
    m_araddr[m]  = addr;
    m_arlen[m]   = len;
    m_arsize[m]  = 3'd2;
    m_arvalid[m] = 1'b1;
  endtask

  task automatic req_write(input bit m, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    m_awaddr[m]  = addr;
    m_awlen[m]   = 8'd0;
    m_awsize[m]  = 3'd2;
    m_awvalid[m] = 1'b1;
    m_wdata[m]   = data;
    m_wstrb[m]   = strb;
    m_wlast[m]   = 1'b1;
    m_wvalid[m]  = 1'b1;
  endtask

  // Returns at the negedge where master m is first granted; n counts edges waited.
  task automatic wait_grant(input bit m, input bit rd, output int n);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((rd ? m_arready[m] : m_awready[m]) === 1'b1) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic serve_read(input bit m, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] dbase, input int m1_req_beat, input int rst_beat);
    int n;
    bit o;
    o = ~m;
    wait_grant(m, 1'b1, n);
    check("rd_lat", n, 1);
    check("s_arvalid", s_arvalid, 1);
    check("s_araddr", s_araddr, addr);
    check("s_arlen", s_arlen, len);
    check("oth_rdy", {m_arready[o], m_awready[o], m_wready[o]}, 0);
    tick();
    m_arvalid[m] = 1'b0;
    m_rready[m]  = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      s_rvalid = 1'b1;
      s_rdata  = dbase + 32'(i);
      s_rresp  = 2'b00;
      s_rlast  = (i == int'(len));
      if (i == m1_req_beat) req_write(1'b1, 32'h2000_0000, 32'h5555_AAAA, 4'hF);
      if (i == rst_beat) begin
        reset = 1'b1;
        #1;
        check("rst_mid_vr", all_vr, 0);
        return;
      end
      @(negedge clk);
      check("m_rvalid", m_rvalid[m], 1);
      check("m_rdata", m_rdata[m], dbase + 32'(i));
      check("m_rlast", m_rlast[m], (i == int'(len)));
      check("oth_rv", {m_rvalid[o], m_awready[o], m_arready[o]}, 0);
      tick();
    end
    s_rvalid     = 1'b0;
    s_rlast      = 1'b0;
    m_rready[m]  = 1'b0;
  endtask

  task automatic serve_write(input bit m, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    int n;
    bit o;
    o = ~m;
    wait_grant(m, 1'b0, n);
    check("wr_lat", n, 1);
    check("s_awvalid", s_awvalid, 1);
    check("s_awaddr", s_awaddr, addr);
    check("s_wvalid", s_wvalid, 1);
    check("s_wdata", s_wdata, data);
    check("s_wstrb", s_wstrb, strb);
    check("s_wlast", s_wlast, 1);
    check("m_wready", m_wready[m], 1);
    check("oth_rdy", {m_arready[o], m_awready[o], m_wready[o]}, 0);
    tick();
    m_awvalid[m] = 1'b0;
    m_wvalid[m]  = 1'b0;
    m_bready[m]  = 1'b1;
    s_bvalid     = 1'b1;
    s_bresp      = 2'b00;
    @(negedge clk);
    check("m_bvalid", m_bvalid[m], 1);
    check("m_bresp", m_bresp[m], 0);
    check("s_bready", s_bready, 1);
    check("oth_bv", m_bvalid[o], 0);
    tick();
    s_bvalid     = 1'b0;
    m_bready[m]  = 1'b0;
  endtask

  task automatic clear_masters();
    for (int i = 0; i < 2; i++) begin
      m_araddr[i] = '0; m_arlen[i] = '0; m_arsize[i] = '0;
      m_awaddr[i] = '0; m_awlen[i] = '0; m_awsize[i] = '0;
      m_wdata[i]  = '0; m_wstrb[i] = '0;
    end
    m_arvalid = '0; m_rready = '0; m_awvalid = '0;
    m_wlast   = '0; m_wvalid = '0; m_bready  = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  bit exp_w;

  initial begin
    reset     = 1'b1;
    clear_masters();
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    s_rvalid  = 1'b0; s_rlast   = 1'b0; s_rdata  = '0; s_rresp = '0;
    s_bvalid  = 1'b0; s_bresp   = '0;
    repeat (2) tick();
    @(negedge clk);
    check("reset_vr", all_vr, 0);
    tick();
    reset = 1'b0;

    // Single m0 read, one beat.
    req_read(1'b0, 32'h8000_0000, 8'd0);
    serve_read(1'b0, 32'h8000_0000, 8'd0, 32'h1111_0000, -1, -1);
    @(negedge clk);
    check("idle_after_rd", all_vr, 0);
    tick();

    // m1 single write while m0 is quiet.
    req_write(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
    serve_write(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
    @(negedge clk);
    check("idle_after_wr", all_vr, 0);
    tick();

    // A request withdrawn before any edge sees it is never granted.
    m_arvalid[0] = 1'b1;
    #2;
    m_arvalid[0] = 1'b0;
    tick();
    @(negedge clk);
    check("drop_vr", all_vr, 0);
    tick();

    // Contention: m0 read against m1 write (last_grant is m1 here).
`ifdef ARB_ROUND_ROBIN_EN
    exp_w = 1'b0;
`else
    exp_w = 1'b1;
`endif
    req_read(1'b0, 32'h8000_0010, 8'd0);
    req_write(1'b1, 32'h0000_1010, 32'hCAFE_F00D, 4'hF);
    if (exp_w) begin
      serve_write(1'b1, 32'h0000_1010, 32'hCAFE_F00D, 4'hF);
      serve_read(1'b0, 32'h8000_0010, 8'd0, 32'h2222_0000, -1, -1);
    end else begin
      serve_read(1'b0, 32'h8000_0010, 8'd0, 32'h2222_0000, -1, -1);
      serve_write(1'b1, 32'h0000_1010, 32'hCAFE_F00D, 4'hF);
    end
    tick();

    // Sustained contention from reset: winner re-requests during the IDLE cycle.
    pulse_reset();
    req_read(1'b0, 32'h8000_0200, 8'd0);
    req_write(1'b1, 32'h0000_2000, 32'h0BAD_0000, 4'hF);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_w = k[0];
`else
      exp_w = 1'b1;
`endif
      if (!exp_w) begin
        serve_read(1'b0, 32'h8000_0200, 8'd0, 32'h3300_0000 + 32'(k), -1, -1);
        if (k < 3) req_read(1'b0, 32'h8000_0200, 8'd0);
      end else begin
        serve_write(1'b1, 32'h0000_2000, 32'h0BAD_0000, 4'hF);
        if (k < 3) req_write(1'b1, 32'h0000_2000, 32'h0BAD_0000, 4'hF);
      end
    end
    serve_read(1'b0, 32'h8000_0200, 8'd0, 32'h3400_0000, -1, -1);
    tick();

    // m0 4-beat burst; m1 arrives at beat 1 and must wait for rlast plus one IDLE cycle.
    req_read(1'b0, 32'h8000_0100, 8'd3);
    serve_read(1'b0, 32'h8000_0100, 8'd3, 32'h4400_0000, 1, -1);
    serve_write(1'b1, 32'h2000_0000, 32'h5555_AAAA, 4'hF);
    tick();

    // Reset during the second beat of a burst, then a fresh m1 read.
    req_read(1'b0, 32'h8000_0300, 8'd3);
    serve_read(1'b0, 32'h8000_0300, 8'd3, 32'h5500_0000, -1, 1);
    clear_masters();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    @(negedge clk);
    check("rst_hold_vr", all_vr, 0);
    tick();
    reset = 1'b0;
    req_read(1'b1, 32'h3000_0000, 8'd0);
    serve_read(1'b1, 32'h3000_0000, 8'd0, 32'h6600_0000, -1, -1);
    @(negedge clk);
    check("idle_final", all_vr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
